// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage core (Q1 fetch .. Q5 writeback).
// Resolves memory-wait stalls in Q4, Q3 redirects and load-use hazards, in that
// priority. Enables/flushes are combinational from state and inputs.
// Optional memory-wait watchdog: define PIPE_HAZARD_MEM_TIMEOUT_EN.
module pipe_hazard_ctrl #(
    parameter int unsigned CNT_WIDTH      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [4:0]           i_q2_rs1,
    input  logic [4:0]           i_q2_rs2,
    input  logic                 i_q2_use_rs1,
    input  logic                 i_q2_use_rs2,
    input  logic [4:0]           i_q3_rd,
    input  logic                 i_q3_mem_rd,
    input  logic                 i_q3_redirect,
    input  logic                 i_q4_mem_req,
    input  logic                 i_dmem_ready,
    output logic                 o_dmem_valid,
    output logic                 o_en_pc,
    output logic                 o_en_q1q2,
    output logic                 o_en_q2q3,
    output logic                 o_en_q3q4,
    output logic                 o_en_q4q5,
    output logic                 o_flush_q1q2,
    output logic                 o_flush_q2q3,
    output logic                 o_flush_q4q5,
    output logic [CNT_WIDTH-1:0] o_stall_cycles,
    output logic                 o_mem_fault
);

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_MEM_WAIT = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic                 load_use_c;
    logic                 mem_stall_c;
    logic                 timeout_c;

    // Q2 reads a register that the Q3 load has not produced yet; x0 is never a hazard
    always_comb begin
        load_use_c = i_q3_mem_rd && (i_q3_rd != 5'd0) &&
                     ((i_q2_use_rs1 && (i_q2_rs1 == i_q3_rd)) ||
                      (i_q2_use_rs2 && (i_q2_rs2 == i_q3_rd)));
    end

`ifdef PIPE_HAZARD_MEM_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            mem_fault_q, mem_fault_d;

    // Watchdog: the TIMEOUT_CYCLES-th unanswered MEM_WAIT cycle retires Q4 as a bubble
    always_comb begin
        timeout_c   = (state_q == S_MEM_WAIT) && !i_dmem_ready &&
                      (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
        wd_d        = '0;
        mem_fault_d = mem_fault_q | timeout_c;
        if (i_rst) begin
            mem_fault_d = 1'b0;
        end else if ((state_q == S_MEM_WAIT) && !i_dmem_ready && !timeout_c) begin
            wd_d = wd_q + WD_W'(1);
        end
    end

    // Watchdog count and sticky fault flag
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wd_q        <= '0;
            mem_fault_q <= 1'b0;
        end else begin
            wd_q        <= wd_d;
            mem_fault_q <= mem_fault_d;
        end
    end

    assign o_mem_fault = mem_fault_q;
`else
    logic [31:0] unused_timeout_c;

    assign unused_timeout_c = TIMEOUT_CYCLES;
    assign timeout_c        = 1'b0;
    assign o_mem_fault      = 1'b0;
`endif

    // Next state and pipeline control; memory stall outranks redirect outranks load-use
    always_comb begin
        state_d      = state_q;
        mem_stall_c  = 1'b0;
        o_dmem_valid = 1'b0;
        o_en_pc      = 1'b1;
        o_en_q1q2    = 1'b1;
        o_en_q2q3    = 1'b1;
        o_en_q3q4    = 1'b1;
        o_en_q4q5    = 1'b1;
        o_flush_q1q2 = 1'b0;
        o_flush_q2q3 = 1'b0;
        o_flush_q4q5 = 1'b0;

        if (i_rst) begin
            state_d      = S_IDLE;
            o_en_pc      = 1'b0;
            o_en_q1q2    = 1'b0;
            o_en_q2q3    = 1'b0;
            o_en_q3q4    = 1'b0;
            o_en_q4q5    = 1'b0;
            o_flush_q1q2 = 1'b1;
            o_flush_q2q3 = 1'b1;
            o_flush_q4q5 = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_q4_mem_req) begin
                        o_dmem_valid = 1'b1;
                        if (!i_dmem_ready) begin
                            mem_stall_c = 1'b1;
                            state_d     = S_MEM_WAIT;
                        end
                    end
                end
                S_MEM_WAIT: begin
                    if (i_dmem_ready) begin
                        o_dmem_valid = 1'b1;
                        state_d      = S_IDLE;
                    end else if (timeout_c) begin
                        o_flush_q4q5 = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        o_dmem_valid = 1'b1;
                        mem_stall_c  = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            if (mem_stall_c) begin
                o_en_pc      = 1'b0;
                o_en_q1q2    = 1'b0;
                o_en_q2q3    = 1'b0;
                o_en_q3q4    = 1'b0;
                o_flush_q4q5 = 1'b1;
            end else if (i_q3_redirect) begin
                o_flush_q1q2 = 1'b1;
                o_flush_q2q3 = 1'b1;
            end else if (load_use_c) begin
                o_en_pc      = 1'b0;
                o_en_q1q2    = 1'b0;
                o_flush_q2q3 = 1'b1;
            end
        end
    end

    // Saturating count of cycles with the PC held
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (i_rst) begin
            stall_cnt_d = '0;
        end else if (!o_en_pc && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
    end

    // State and counter registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed vector table, hand-written
// multi-cycle sequences and randomized stimulus against a behavioural model.
// Define PIPE_HAZARD_MEM_TIMEOUT_EN to exercise the watchdog sequence.
module tb_pipe_hazard_ctrl;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned T_OUT   = 4;
    localparam int          MAX_CNT = 15;

    // Output vector bit order: valid, en_pc, en_q1q2, en_q2q3, en_q3q4, en_q4q5,
    // flush_q1q2, flush_q2q3, flush_q4q5
    localparam logic [8:0] P_NORM  = 9'b0_11111_000;
    localparam logic [8:0] P_LU    = 9'b0_00111_010;
    localparam logic [8:0] P_REDIR = 9'b0_11111_110;
    localparam logic [8:0] P_MEMOK = 9'b1_11111_000;
    localparam logic [8:0] P_MSTL  = 9'b1_00001_001;
    localparam logic [8:0] P_RST   = 9'b0_00000_111;

    logic             i_clk;
    logic             i_rst;
    logic [4:0]       i_q2_rs1, i_q2_rs2, i_q3_rd;
    logic             i_q2_use_rs1, i_q2_use_rs2;
    logic             i_q3_mem_rd, i_q3_redirect, i_q4_mem_req, i_dmem_ready;
    logic             o_dmem_valid, o_en_pc, o_en_q1q2, o_en_q2q3, o_en_q3q4, o_en_q4q5;
    logic             o_flush_q1q2, o_flush_q2q3, o_flush_q4q5;
    logic [CNT_W-1:0] o_stall_cycles;
    logic             o_mem_fault;

    pipe_hazard_ctrl #(
        .CNT_WIDTH      (CNT_W),
        .TIMEOUT_CYCLES (T_OUT)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_q2_rs1       (i_q2_rs1),
        .i_q2_rs2       (i_q2_rs2),
        .i_q2_use_rs1   (i_q2_use_rs1),
        .i_q2_use_rs2   (i_q2_use_rs2),
        .i_q3_rd        (i_q3_rd),
        .i_q3_mem_rd    (i_q3_mem_rd),
        .i_q3_redirect  (i_q3_redirect),
        .i_q4_mem_req   (i_q4_mem_req),
        .i_dmem_ready   (i_dmem_ready),
        .o_dmem_valid   (o_dmem_valid),
        .o_en_pc        (o_en_pc),
        .o_en_q1q2      (o_en_q1q2),
        .o_en_q2q3      (o_en_q2q3),
        .o_en_q3q4      (o_en_q3q4),
        .o_en_q4q5      (o_en_q4q5),
        .o_flush_q1q2   (o_flush_q1q2),
        .o_flush_q2q3   (o_flush_q2q3),
        .o_flush_q4q5   (o_flush_q4q5),
        .o_stall_cycles (o_stall_cycles),
        .o_mem_fault    (o_mem_fault)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic [4:0] rd;
        logic       mem_rd;
        logic       redirect;
        logic       req;
        logic       ready;
    } in_t;

    typedef struct {
        in_t        in;
        logic [8:0] exp;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;

    // Behavioural model state: cycles the current Q4 access has been refused so far,
    // stall count, sticky fault.
    int   m_wait  = 0;
    int   m_cnt   = 0;
    logic m_fault = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input in_t v);
        i_rst         = v.rst;
        i_q2_rs1      = v.rs1;
        i_q2_rs2      = v.rs2;
        i_q2_use_rs1  = v.use1;
        i_q2_use_rs2  = v.use2;
        i_q3_rd       = v.rd;
        i_q3_mem_rd   = v.mem_rd;
        i_q3_redirect = v.redirect;
        i_q4_mem_req  = v.req;
        i_dmem_ready  = v.ready;
    endtask

    function automatic logic [8:0] dut_vec();
        return {o_dmem_valid, o_en_pc, o_en_q1q2, o_en_q2q3, o_en_q3q4, o_en_q4q5,
                o_flush_q1q2, o_flush_q2q3, o_flush_q4q5};
    endfunction

    // One clock: model predicts outputs from the rules, compares, then advances.
    task automatic cycle(input string name, input logic chk, input logic [8:0] texp);
        logic [8:0] e;
        logic       v, to, stall, lu;
        int         nw, ncnt;
        logic       nf;
        #2;
        e    = P_NORM;
        nw   = 0;
        ncnt = m_cnt;
        nf   = m_fault;
        if (i_rst) begin
            e    = P_RST;
            ncnt = 0;
            nf   = 1'b0;
        end else begin
            lu = i_q3_mem_rd && (i_q3_rd != 5'd0) &&
                 ((i_q2_use_rs1 && (i_q2_rs1 == i_q3_rd)) ||
                  (i_q2_use_rs2 && (i_q2_rs2 == i_q3_rd)));
            v  = (m_wait > 0) || i_q4_mem_req;
            to = 1'b0;
`ifdef PIPE_HAZARD_MEM_TIMEOUT_EN
            to = (m_wait > 0) && !i_dmem_ready && (m_wait == int'(T_OUT));
`endif
            stall = v && !i_dmem_ready && !to;
            if (stall) begin
                e  = P_MSTL;
                nw = m_wait + 1;
            end else begin
                e[8] = v && !to;
                e[0] = to;
                if (i_q3_redirect) begin
                    e[2] = 1'b1;
                    e[1] = 1'b1;
                end else if (lu) begin
                    e[7] = 1'b0;
                    e[6] = 1'b0;
                    e[1] = 1'b1;
                end
            end
            if (!e[7] && (m_cnt < MAX_CNT)) ncnt = m_cnt + 1;
            nf = m_fault | to;
        end
        check({name, "_out"}, 32'(dut_vec()), 32'(e));
        if (chk) check({name, "_tbl"}, 32'(dut_vec()), 32'(texp));
        check({name, "_cnt"}, 32'(o_stall_cycles), 32'(m_cnt));
        check({name, "_fault"}, 32'(o_mem_fault), 32'(m_fault));
        @(posedge i_clk);
        m_wait  = nw;
        m_cnt   = ncnt;
        m_fault = nf;
        #1;
    endtask

    function automatic in_t idle_in();
        in_t v;
        v = '0;
        return v;
    endfunction

    task automatic do_reset();
        in_t v;
        v     = idle_in();
        v.rst = 1'b1;
        apply(v);
        cycle("rst", 1'b1, P_RST);
        apply(idle_in());
    endtask

    vec_t tbl[11];

    initial begin
        in_t v;

        // Directed single-cycle vectors, all starting from IDLE with no wait pending
        for (int i = 0; i < 11; i++) tbl[i].in = idle_in();
        tbl[0].exp = P_NORM;
        tbl[1].in.mem_rd = 1; tbl[1].in.rd = 5; tbl[1].in.use1 = 1; tbl[1].in.rs1 = 5;
        tbl[1].exp = P_LU;
        tbl[2].in.mem_rd = 1; tbl[2].in.rd = 0; tbl[2].in.use1 = 1; tbl[2].in.rs1 = 0;
        tbl[2].exp = P_NORM;
        tbl[3].in.mem_rd = 1; tbl[3].in.rd = 7; tbl[3].in.use2 = 1; tbl[3].in.rs2 = 7;
        tbl[3].exp = P_LU;
        tbl[4].in.mem_rd = 1; tbl[4].in.rd = 7; tbl[4].in.use2 = 0; tbl[4].in.rs2 = 7;
        tbl[4].exp = P_NORM;
        tbl[5].in.mem_rd = 0; tbl[5].in.rd = 9; tbl[5].in.use1 = 1; tbl[5].in.rs1 = 9;
        tbl[5].exp = P_NORM;
        tbl[6].in.mem_rd = 1; tbl[6].in.rd = 5; tbl[6].in.use1 = 1; tbl[6].in.rs1 = 5;
        tbl[6].in.redirect = 1;
        tbl[6].exp = P_REDIR;
        tbl[7].in.req = 1; tbl[7].in.ready = 1;
        tbl[7].exp = P_MEMOK;
        tbl[8].in.req = 1; tbl[8].in.ready = 1;
        tbl[8].in.mem_rd = 1; tbl[8].in.rd = 3; tbl[8].in.use2 = 1; tbl[8].in.rs2 = 3;
        tbl[8].exp = 9'b1_00111_010;
        tbl[9].in.rst = 1; tbl[9].in.req = 1;
        tbl[9].exp = P_RST;
        tbl[10].in.rst = 1; tbl[10].in.redirect = 1; tbl[10].in.req = 1;
        tbl[10].exp = P_RST;

        v     = idle_in();
        v.rst = 1'b1;
        apply(v);
        repeat (2) @(posedge i_clk);
        #1;
        do_reset();

        for (int i = 0; i < 11; i++) begin
            apply(tbl[i].in);
            cycle($sformatf("table%0d", i), 1'b1, tbl[i].exp);
        end
        apply(idle_in());

        // Load-use: exactly one bubble, count 1
        do_reset();
        v = idle_in(); v.mem_rd = 1; v.rd = 5; v.use1 = 1; v.rs1 = 5;
        apply(v);
        cycle("lu", 1'b1, P_LU);
        apply(idle_in());
        cycle("lu_after", 1'b1, P_NORM);
        check("lu_cnt", 32'(o_stall_cycles), 32'd1);

        // Redirect suppresses load-use; count unchanged
        v = idle_in(); v.mem_rd = 1; v.rd = 5; v.use1 = 1; v.rs1 = 5; v.redirect = 1;
        apply(v);
        cycle("redir_lu", 1'b1, P_REDIR);
        check("redir_cnt", 32'(o_stall_cycles), 32'd1);

        // Memory wait: ready low 3 cycles then high
        do_reset();
        v = idle_in(); v.req = 1;
        apply(v);
        for (int i = 0; i < 3; i++) cycle("mwait", 1'b1, P_MSTL);
        v.ready = 1;
        apply(v);
        cycle("mwait_rdy", 1'b1, P_MEMOK);
        apply(idle_in());
        cycle("mwait_idle", 1'b1, P_NORM);
        check("mwait_cnt", 32'(o_stall_cycles), 32'd3);

        // Redirect and load-use during a memory stall are deferred to the ready cycle
        do_reset();
        v = idle_in(); v.req = 1; v.redirect = 1; v.mem_rd = 1; v.rd = 2; v.use1 = 1; v.rs1 = 2;
        apply(v);
        cycle("defer", 1'b1, P_MSTL);
        cycle("defer", 1'b1, P_MSTL);
        v.ready = 1;
        apply(v);
        cycle("defer_rdy", 1'b1, 9'b1_11111_110);
        check("defer_cnt", 32'(o_stall_cycles), 32'd2);

        // Back-to-back zero-wait accesses
        do_reset();
        v = idle_in(); v.req = 1; v.ready = 1;
        apply(v);
        for (int i = 0; i < 3; i++) cycle("b2b", 1'b1, P_MEMOK);
        check("b2b_cnt", 32'(o_stall_cycles), 32'd0);

        // Reset in the middle of a wait abandons the access
        do_reset();
        v = idle_in(); v.req = 1;
        apply(v);
        cycle("rstwait", 1'b1, P_MSTL);
        cycle("rstwait", 1'b1, P_MSTL);
        v.rst = 1;
        apply(v);
        cycle("rstwait_rst", 1'b1, P_RST);
        apply(idle_in());
        cycle("rstwait_idle", 1'b1, P_NORM);
        check("rstwait_cnt", 32'(o_stall_cycles), 32'd0);

        // Counter saturates at all-ones
        do_reset();
        v = idle_in(); v.mem_rd = 1; v.rd = 4; v.use2 = 1; v.rs2 = 4;
        apply(v);
        for (int i = 0; i < 20; i++) cycle("sat", 1'b1, P_LU);
        check("sat_cnt", 32'(o_stall_cycles), 32'(MAX_CNT));

`ifdef PIPE_HAZARD_MEM_TIMEOUT_EN
        // Watchdog: four refused cycles, then Q4 retires as a bubble and fault sticks
        do_reset();
        v = idle_in(); v.req = 1;
        apply(v);
        for (int i = 0; i < 4; i++) cycle("wd", 1'b1, P_MSTL);
        cycle("wd_to", 1'b1, 9'b0_11111_001);
        check("wd_fault", 32'(o_mem_fault), 32'd1);
        check("wd_cnt", 32'(o_stall_cycles), 32'd4);
        apply(idle_in());
        for (int i = 0; i < 3; i++) cycle("wd_resume", 1'b1, P_NORM);
        v = idle_in(); v.req = 1; v.ready = 1;
        apply(v);
        cycle("wd_next", 1'b1, P_MEMOK);
        check("wd_sticky", 32'(o_mem_fault), 32'd1);
        do_reset();
        check("wd_clr", 32'(o_mem_fault), 32'd0);
`else
        // Without the watchdog the wait is unbounded and no fault appears
        do_reset();
        v = idle_in(); v.req = 1;
        apply(v);
        for (int i = 0; i < 10; i++) cycle("nowd", 1'b1, P_MSTL);
        check("nowd_fault", 32'(o_mem_fault), 32'd0);
        v.ready = 1;
        apply(v);
        cycle("nowd_rdy", 1'b1, P_MEMOK);
`endif

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            v          = idle_in();
            v.rst      = ($urandom_range(0, 63) == 0);
            v.rs1      = 5'($urandom_range(0, 3));
            v.rs2      = 5'($urandom_range(0, 3));
            v.rd       = 5'($urandom_range(0, 3));
            v.use1     = 1'($urandom);
            v.use2     = 1'($urandom);
            v.mem_rd   = 1'($urandom);
            v.redirect = ($urandom_range(0, 3) == 0);
            v.req      = 1'($urandom);
            v.ready    = 1'($urandom);
            apply(v);
            cycle("rand", 1'b0, 9'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage core: Q1 fetch, Q2 decode, Q3 execute, Q4 memory, Q5 writeback.
- Drives hold-enable and bubble-flush strobes for the PC and the q1q2, q2q3, q3q4 and q4q5 pipeline registers.
- Resolves three hazards: load-use hazards, Q3 control-flow redirects, and multi-cycle data-memory handshakes in Q4.
- Keeps a saturating count of stall cycles.

Parameters:
- CNT_WIDTH, 32, width of the stall-cycle counter.
- TIMEOUT_CYCLES, 255, memory-wait watchdog limit. Used only with MEM_TIMEOUT_EN.

Ports:
- i_clk  input  1  core clock
- i_rst  input  1  synchronous reset, active-high
- i_q2_rs1  input  5  source register 1 of the Q2 instruction
- i_q2_rs2  input  5  source register 2 of the Q2 instruction
- i_q2_use_rs1  input  1  Q2 instruction reads rs1
- i_q2_use_rs2  input  1  Q2 instruction reads rs2
- i_q3_rd  input  5  destination register of the Q3 instruction
- i_q3_mem_rd  input  1  Q3 instruction is a load
- i_q3_redirect  input  1  Q3 branch taken or jump
- i_q4_mem_req  input  1  Q4 instruction accesses data memory
- i_dmem_ready  input  1  data-memory handshake ready
- o_dmem_valid  output  1  data-memory handshake valid
- o_en_pc  output  1  PC update enable
- o_en_q1q2  output  1  q1q2 capture enable
- o_en_q2q3  output  1  q2q3 capture enable
- o_en_q3q4  output  1  q3q4 capture enable
- o_en_q4q5  output  1  q4q5 capture enable
- o_flush_q1q2  output  1  q1q2 loads bubble (instr 0x00000013, ctrl 0)
- o_flush_q2q3  output  1  q2q3 loads bubble
- o_flush_q4q5  output  1  q4q5 loads bubble
- o_stall_cycles  output  CNT_WIDTH  saturating count of stalled cycles
- o_mem_fault  output  1  sticky watchdog fault (0 unless MEM_TIMEOUT_EN)

Behaviour:
- State: FSM {IDLE, MEM_WAIT}, stall counter, optional watchdog counter. All outputs are combinational from state and inputs.
- Reset (i_rst=1 at a clock edge): FSM goes to IDLE; o_stall_cycles, watchdog and o_mem_fault clear.
- While i_rst=1: all o_en_* = 0, all o_flush_* = 1, o_dmem_valid = 0. Reset mid-wait abandons the transaction; valid drops with no ready required.
- Default (no hazard): all enables = 1, all flushes = 0.
- Memory stall:
  - In IDLE, i_q4_mem_req=1 drives o_dmem_valid=1.
  - If i_dmem_ready=1 in the same cycle: zero-stall, normal advance.
  - Otherwise go to MEM_WAIT. In MEM_WAIT, o_dmem_valid stays 1 until the ready cycle; valid must not drop before ready.
  - Any cycle with valid=1 and ready=0: o_en_pc, o_en_q1q2, o_en_q2q3, o_en_q3q4 = 0; o_en_q4q5 = 1 with o_flush_q4q5 = 1 (bubble into Q5).
  - Ready in MEM_WAIT: advance normally that cycle and return to IDLE.
  - Back-to-back Q4 requests: the next request may begin valid the cycle after ready.
- Load-use hazard: i_q3_mem_rd=1, i_q3_rd!=0, and (i_q2_use_rs1 and rs1==rd, or i_q2_use_rs2 and rs2==rd).
  - Response: o_en_pc=0, o_en_q1q2=0, o_flush_q2q3=1. Exactly one bubble, since Q3 advances the next cycle.
  - rd=x0 never stalls.
- Redirect: i_q3_redirect=1 gives o_flush_q1q2=1 and o_flush_q2q3=1; PC is enabled to load the target.
- Priority: memory stall > redirect > load-use.
  - Redirect suppresses load-use, because the dependent instruction is squashed.
  - Redirect or load-use during a memory stall is deferred. Q3 is frozen, so it re-presents when the stall clears.
- Stall counter: increments once per cycle in which o_en_pc=0 outside reset; saturates at all-ones.
- Without MEM_TIMEOUT_EN, o_mem_fault is tied to 0.

Optional Feature:
- Macro: PIPE_HAZARD_MEM_TIMEOUT_EN.
- Enabled:
  - The watchdog counts consecutive MEM_WAIT cycles.
  - On reaching TIMEOUT_CYCLES with no ready: set o_mem_fault (sticky until reset), drop o_dmem_valid, return to IDLE, retire the Q4 instruction as a bubble (o_flush_q4q5=1, all enables=1). The pipeline then resumes.
  - The watchdog clears on ready or on leaving MEM_WAIT.
- Disabled: no watchdog logic; MEM_WAIT waits indefinitely; o_mem_fault = 0.

Test Plan:
- Load-use: Q3 load rd=5, Q2 use_rs1=1 rs1=5 -> one cycle with en_pc=0, en_q1q2=0, flush_q2q3=1, then all enables 1; stall_cycles=1. Same case with rd=0 -> no stall.
- Redirect plus load-use in the same cycle -> flush_q1q2=1, flush_q2q3=1, en_pc=1, no stall; stall_cycles unchanged.
- Memory wait: mem_req=1, ready low for 3 cycles then high -> dmem_valid high 4 cycles continuously; en_pc..en_q3q4 low 3 cycles; flush_q4q5 high 3 cycles; stall_cycles=3; FSM back to IDLE.
- Zero-wait access: mem_req=1, ready=1 in the same cycle -> no stall, FSM stays IDLE. Back-to-back requests each get valid.
- Reset mid-MEM_WAIT: assert i_rst after 2 wait cycles -> dmem_valid=0, all flushes=1, enables=0; after release FSM in IDLE, stall_cycles=0.
- With PIPE_HAZARD_MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4: ready held low -> after 4 wait cycles o_mem_fault=1 (sticky), dmem_valid=0, pipeline resumes; o_mem_fault stays 1 until i_rst.
